// File: rtl/neuron_param_loader_pkg.sv
// Shared widths, the idle sentinel and the loader state encoding.
package neuron_param_loader_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int CFG_WIDTH  = 2 * DATA_WIDTH + 1;

    // config_* value that matches no neuron: the bus is parked on it while idle.
    localparam logic [CFG_WIDTH-1:0] CFG_IDLE_SENTINEL = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_B = 2'd2,
        FIN    = 2'd3
    } load_state_e;

endpackage

// File: rtl/neuron_param_loader_counter.sv
// Terminal-count counter: clears to 0, counts up on enable and holds at
// TERMINAL-1 instead of wrapping. Callers wrap it explicitly via clr.
module neuron_param_loader_counter #(
    parameter int unsigned TERMINAL = 4,
    parameter int unsigned WIDTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    // Count with clear priority; saturate at the terminal value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/neuron_param_loader.sv
// Writer side of the neuron weight/bias load bus. Accepts a ready/valid word
// stream and issues, per neuron, numWeight weight strobes followed by one bias
// strobe, steering config_layer_num/config_neuron_num so one neuron captures it.
//
// Handshake: a word is transferred on a rising edge where s_valid && s_ready;
// s_ready depends only on state (never on s_valid), and each transferred word
// produces exactly one strobe in the following cycle.
module neuron_param_loader
    import neuron_param_loader_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int numWeight = 128,
    parameter int numNeuron = 64,
    parameter int cfgWidth  = 2 * dataWidth + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [cfgWidth-1:0]  start_layer,
    input  logic [dataWidth-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 weightValid,
    output logic [dataWidth-1:0] weightValue,
    output logic                 biasValid,
    output logic [dataWidth-1:0] biasValue,
    output logic [cfgWidth-1:0]  config_layer_num,
    output logic [cfgWidth-1:0]  config_neuron_num,
    output logic                 busy,
    output logic                 done
);

    localparam int WCW = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam int NCW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam logic [cfgWidth-1:0] SENTINEL = {cfgWidth{CFG_IDLE_SENTINEL[0]}};

    load_state_e    state;
    logic           advance_neuron;
    logic           handshake;
    logic           start_accept;
    logic           w_en;
    logic           w_clr;
    logic           w_last;
    logic           n_last;
    logic [WCW-1:0] w_cnt;
    logic [NCW-1:0] n_cnt;

    assign s_ready      = (state == LOAD_W) || (state == LOAD_B);
    assign handshake    = s_valid && s_ready;
    assign start_accept = (state == IDLE) && start;
    assign w_en         = handshake && (state == LOAD_W);
    assign w_clr        = start_accept || (w_en && w_last);
    assign w_last       = (w_cnt == WCW'(numWeight - 1));
    assign n_last       = (n_cnt == NCW'(numNeuron - 1));

    // Neuron number is only meaningful while a load is in progress.
    assign config_neuron_num = busy ? cfgWidth'(n_cnt) : SENTINEL;

    neuron_param_loader_counter #(
        .TERMINAL (numWeight),
        .WIDTH    (WCW)
    ) u_weight_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .count (w_cnt)
    );

    // Advances one cycle after the bias handshake, so the bias strobe still
    // carries the neuron it belongs to.
    neuron_param_loader_counter #(
        .TERMINAL (numNeuron),
        .WIDTH    (NCW)
    ) u_neuron_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_accept),
        .en    (advance_neuron),
        .count (n_cnt)
    );

    // Load sequencer with registered strobes, data and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            weightValid      <= 1'b0;
            weightValue      <= '0;
            biasValid        <= 1'b0;
            biasValue        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            config_layer_num <= SENTINEL;
            advance_neuron   <= 1'b0;
        end else begin
            weightValid    <= 1'b0;
            biasValid      <= 1'b0;
            done           <= 1'b0;
            advance_neuron <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        config_layer_num <= start_layer;
                        busy             <= 1'b1;
                        state            <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (handshake) begin
                        weightValid <= 1'b1;
                        weightValue <= s_data;
                        if (w_last) begin
                            state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (handshake) begin
                        biasValid <= 1'b1;
                        biasValue <= s_data;
                        if (n_last) begin
                            state <= FIN;
                        end else begin
                            advance_neuron <= 1'b1;
                            state          <= LOAD_W;
                        end
                    end
                end
                FIN: begin
                    done             <= 1'b1;
                    busy             <= 1'b0;
                    config_layer_num <= SENTINEL;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
